fetch_pc_gen: RTL
=================

Name: fetch_pc_gen

Overview:
- Fetch-stage PC sequencer sitting directly upstream of next_line_predictor.
- Drives fetch_PC/fetch_valid into the predictor each cycle and consumes its same-cycle target_PC/target_take/BTB_hit to choose the next PC.
- Applies back-end redirects (mispredict/exception) with priority and honours i-cache stalls.
- Tags every fetch with an epoch bit so downstream stages can discard wrong-path instructions.

Parameters:
- XLEN, 64, address width.
- RESET_PC, 0, first fetch address after start.
- INSN_BYTES, 4, sequential increment; power of two; low log2(INSN_BYTES) bits of every loaded PC are forced to 0.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  leave IDLE and begin fetching at RESET_PC.
- stall  in  1  i-cache/fetch buffer cannot accept; hold current fetch.
- redirect_valid  in  1  back-end correction this cycle.
- redirect_PC  in  XLEN  corrected fetch address.
- target_PC  in  XLEN  predictor target for the current fetch_PC.
- target_take  in  1  predictor taken hint.
- BTB_hit  in  1  predictor hit for the current fetch_PC.
- fetch_PC  out  XLEN  registered current fetch address (to predictor and i-cache).
- fetch_valid  out  1  fetch_PC is a real request.
- fetch_pred_taken  out  1  BTB_hit & target_take for the current fetch, combinational, forwarded down the pipe.
- fetch_epoch  out  1  epoch tag of the current fetch.

Behaviour:
- Reset (reset=0, async): state=IDLE, fetch_PC=RESET_PC, fetch_valid=0, fetch_epoch=0. The optional counters are also cleared.
- States are IDLE, RUN, STALL.
- IDLE:
  - fetch_valid=0.
  - start=1 -> RUN next cycle with fetch_PC=RESET_PC and fetch_valid=1.
  - redirect_valid in IDLE loads redirect_PC and goes to RUN; this has priority over start.
- RUN:
  - fetch_valid=1.
  - Next-PC priority:
    1. redirect_valid -> redirect_PC, fetch_epoch toggles.
    2. stall -> hold fetch_PC, state=STALL.
    3. BTB_hit & target_take -> target_PC.
    4. Otherwise fetch_PC + INSN_BYTES (mod 2^XLEN, wraps to 0 silently).
- STALL:
  - fetch_valid=1; fetch_PC is held unchanged.
  - The predictor is re-consulted each cycle on the same PC.
  - stall=0 -> RUN, and the next-PC is chosen as in RUN for that cycle. The predictor output sampled on the cycle stall drops is used.
  - redirect_valid while stalled: load redirect_PC and toggle the epoch. State is STALL if stall is still 1, else RUN.
- Redirect and prediction landing in the same cycle: the redirect wins and the prediction is dropped.
- Redirect has one cycle of latency: the redirect_PC appears on fetch_PC the cycle after redirect_valid.
- Alignment: any loaded PC (redirect or target) has its low log2(INSN_BYTES) bits cleared.
- A new reset assertion mid-operation immediately returns to the reset state regardless of stall or redirect.
- fetch_pred_taken is 0 whenever fetch_valid=0.
- start is ignored outside IDLE.

Optional Feature:
- Macro: FETCH_PC_GEN_STATS_EN.
- When defined, adds three outputs:
  - stat_fetches (32): counts cycles with fetch_valid=1 and stall=0.
  - stat_pred_taken (32): counts accepted fetches with fetch_pred_taken=1.
  - stat_redirects (32): counts redirect_valid cycles outside reset.
- Counters saturate at all-ones and are cleared by reset.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset and start: hold reset=0 for 5 cycles -> fetch_valid=0, fetch_PC=0. Release, pulse start -> next cycle fetch_valid=1, fetch_PC=0, then 4, 8, 0xC on successive cycles.
- Predicted jump: at fetch_PC=0x10 drive BTB_hit=1, target_take=1, target_PC=0x80 -> fetch_pred_taken=1 that cycle; next fetch_PC=0x80, then 0x84. With BTB_hit=0, target_take=1 -> next is 0x14.
- Stall: assert stall at fetch_PC=0x20 for 3 cycles -> fetch_PC stays 0x20 with fetch_valid=1. Release -> 0x24.
- Redirect vs prediction: same cycle redirect_valid=1, redirect_PC=0x203, prediction to 0x80 -> next fetch_PC=0x200 (aligned) and fetch_epoch flips 0->1. A second redirect flips it back to 0.
- Redirect during stall: stall=1, redirect to 0x400 -> fetch_PC=0x400 and held while stall=1. stall=0 -> 0x404.
- Wrap and async reset: fetch at 0xFFFF_FFFF_FFFF_FFFC, no prediction -> next fetch_PC=0. Assert reset mid-stall between edges -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen_if
//
// Purpose: bundles the request/response signals between the fetch PC
// sequencer and its environment. The environment is the back end (start,
// stall, redirects) and the next-line predictor (target/taken/hit).
//
// Signals:
//   start            env -> gen   leave IDLE and begin fetching
//   stall            env -> gen   i-cache / fetch buffer cannot accept
//   redirect_valid   env -> gen   back-end correction this cycle
//   redirect_PC      env -> gen   corrected fetch address
//   target_PC        env -> gen   predictor target for current fetch_PC
//   target_take      env -> gen   predictor taken hint
//   BTB_hit          env -> gen   predictor hit for current fetch_PC
//   fetch_PC         gen -> env   registered current fetch address
//   fetch_valid      gen -> env   fetch_PC is a real request
//   fetch_pred_taken gen -> env   BTB_hit & target_take, gated by fetch_valid
//   fetch_epoch      gen -> env   epoch tag of the current fetch
//
// Modports:
//   master  the PC sequencer (drives the fetch request)
//   slave   the surrounding back end / predictor / bench
// ---------------------------------------------------------------------------
interface fetch_pc_gen_if #(
  parameter int XLEN = 64
);
  logic            start;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_PC;
  logic [XLEN-1:0] target_PC;
  logic            target_take;
  logic            BTB_hit;
  logic [XLEN-1:0] fetch_PC;
  logic            fetch_valid;
  logic            fetch_pred_taken;
  logic            fetch_epoch;

  modport master (
    input  start,
    input  stall,
    input  redirect_valid,
    input  redirect_PC,
    input  target_PC,
    input  target_take,
    input  BTB_hit,
    output fetch_PC,
    output fetch_valid,
    output fetch_pred_taken,
    output fetch_epoch
  );

  modport slave (
    output start,
    output stall,
    output redirect_valid,
    output redirect_PC,
    output target_PC,
    output target_take,
    output BTB_hit,
    input  fetch_PC,
    input  fetch_valid,
    input  fetch_pred_taken,
    input  fetch_epoch
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//
// Purpose: fetch-stage PC sequencer sitting directly upstream of the
// next-line predictor. Each cycle it presents fetch_PC/fetch_valid to the
// predictor, consumes the same-cycle target_PC/target_take/BTB_hit, and picks
// the next fetch address. Back-end redirects have top priority and toggle
// the epoch tag so downstream stages can drop wrong-path instructions.
// Stalls hold the current fetch and re-consult the predictor every cycle.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset (0 = in reset)
//   bus     fetch_pc_gen_if.master, see the interface file for signal list
//   stat_fetches    out 32  (optional) accepted fetches (valid & !stall)
//   stat_pred_taken out 32  (optional) accepted fetches predicted taken
//   stat_redirects  out 32  (optional) redirect_valid cycles
//
// Parameters:
//   XLEN        address width
//   RESET_PC    first fetch address after start
//   INSN_BYTES  sequential increment (power of two); low log2 bits of every
//               loaded PC are cleared
//
// Optional feature: define FETCH_PC_GEN_STATS_EN to add the saturating
// statistics counters. Without it the counter ports and logic are absent.
// ---------------------------------------------------------------------------
module fetch_pc_gen #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              INSN_BYTES = 4
) (
  input  logic               clock,
  input  logic               reset,
  fetch_pc_gen_if.master     bus
`ifdef FETCH_PC_GEN_STATS_EN
  ,
  output logic [31:0]        stat_fetches,
  output logic [31:0]        stat_pred_taken,
  output logic [31:0]        stat_redirects
`endif
);

  localparam int              ALIGN_BITS = (INSN_BYTES > 1) ? $clog2(INSN_BYTES) : 0;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~((XLEN'(1) << ALIGN_BITS) - XLEN'(1));
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSN_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  // Clears the instruction-offset bits of any address loaded into fetch_PC.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    return (en && (c != '1)) ? c + 32'd1 : c;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_epoch;
  logic            w_epoch_nxt;
  logic            w_pred_hit;
  logic            w_fetch_valid;
  logic            w_pred_taken;

  assign w_pred_hit = bus.BTB_hit & bus.target_take;

  // State and fetch address registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_epoch <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_epoch <= w_epoch_nxt;
    end
  end

  // Next state / next PC selection
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epoch_nxt = r_epoch;
    unique case (r_state)
      S_IDLE: begin
        // Nothing was fetched yet, so there is no wrong path to kill and
        // the epoch is left alone when a redirect launches fetching.
        if (bus.redirect_valid) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = align_pc(bus.redirect_PC);
        end else if (bus.start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = align_pc(RESET_PC);
        end
      end
      S_RUN, S_STALL: begin
        // RUN and STALL share one priority chain; the predictor output is
        // live in both, so the cycle stall drops uses the fresh prediction.
        if (bus.redirect_valid) begin
          w_pc_nxt    = align_pc(bus.redirect_PC);
          w_epoch_nxt = ~r_epoch;
          w_state_nxt = bus.stall ? S_STALL : S_RUN;
        end else if (bus.stall) begin
          w_state_nxt = S_STALL;
        end else if (w_pred_hit) begin
          w_pc_nxt    = align_pc(bus.target_PC);
          w_state_nxt = S_RUN;
        end else begin
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    w_fetch_valid = (r_state != S_IDLE);
    w_pred_taken  = w_fetch_valid & w_pred_hit;
  end

  assign bus.fetch_PC         = r_pc;
  assign bus.fetch_valid      = w_fetch_valid;
  assign bus.fetch_pred_taken = w_pred_taken;
  assign bus.fetch_epoch      = r_epoch;

`ifdef FETCH_PC_GEN_STATS_EN
  logic [31:0] r_stat_fetches;
  logic [31:0] r_stat_pred_taken;
  logic [31:0] r_stat_redirects;
  logic        w_accept;

  assign w_accept = w_fetch_valid & ~bus.stall;

  // Statistics counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stat_fetches    <= '0;
      r_stat_pred_taken <= '0;
      r_stat_redirects  <= '0;
    end else begin
      r_stat_fetches    <= sat_inc(r_stat_fetches, w_accept);
      r_stat_pred_taken <= sat_inc(r_stat_pred_taken, w_accept & w_pred_taken);
      r_stat_redirects  <= sat_inc(r_stat_redirects, bus.redirect_valid);
    end
  end

  assign stat_fetches    = r_stat_fetches;
  assign stat_pred_taken = r_stat_pred_taken;
  assign stat_redirects  = r_stat_redirects;
`endif

endmodule
